aes_shift_rows_stream: RTL and testbench



---
 rtl/aes_shift_rows_stream.sv | 106 ++++++++++
 tb/tb_aes_shift_rows_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_rows_stream.sv
// Registered AES/Rijndael ShiftRows stage for NB = 4/6/8 columns.
// Forward, inverse or bypass per beat, with a valid/ready output register.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake (in_ready = !out_valid | out_ready)
//   in_data  [W-1:0]       state, byte k = in_data[W-1-8k -: 8], row k%4, col k/4
//   in_mode  [1:0]         00 forward, 01 inverse, 10 bypass, 11 illegal
//   out_valid/out_ready    output handshake
//   out_data [W-1:0]       shifted state, same byte layout
//   out_err                flags a beat accepted with in_mode = 11
module aes_shift_rows_stream #(
    parameter  int NB = 4,
    localparam int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err
);

    // Only the three Rijndael block widths have defined row offsets.
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_stream: NB must be 4, 6 or 8");
    end

    // The 256-bit block uses offsets 0,1,3,4; narrower blocks use 0,1,2,3.
    function automatic int row_shift(input int r);
        if (NB == 8 && r >= 2)
            return r + 1;
        return r;
    endfunction

    logic [W-1:0] w_fwd;
    logic [W-1:0] w_inv;
    logic [W-1:0] w_next;
    logic         w_is_fwd;
    logic         w_is_inv;
    logic         w_is_byp;
    logic         w_is_bad;
    logic         w_in_fire;

    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_err;

    // Pure byte wiring: each output byte picks a fixed source byte.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int S  = row_shift(r);
            localparam int FC = (c + S) % NB;
            localparam int IC = (c - S + NB) % NB;
            localparam int OB = W - 1 - 8 * (4 * c + r);
            localparam int FB = W - 1 - 8 * (4 * FC + r);
            localparam int IB = W - 1 - 8 * (4 * IC + r);

            assign w_fwd[OB -: 8] = in_data[FB -: 8];
            assign w_inv[OB -: 8] = in_data[IB -: 8];
        end
    end

    assign w_is_fwd = (in_mode == 2'b00);
    assign w_is_inv = (in_mode == 2'b01);
    assign w_is_bad = (in_mode == 2'b11);
    // Illegal mode carries the data through untouched.
    assign w_is_byp = in_mode[1];

    always_comb begin
        w_next = in_data;
        unique case (1'b1)
            w_is_fwd: w_next = w_fwd;
            w_is_inv: w_next = w_inv;
            w_is_byp: w_next = in_data;
        endcase
    end

    assign in_ready  = !r_valid | out_ready;
    assign w_in_fire = in_valid & in_ready;

    // A new beat overwrites the register even while the old one drains,
    // so a continuous stream runs without bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_err   <= w_is_bad;
            r_data  <= w_next;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_err   = r_err;

endmodule

// File: tb/tb_aes_shift_rows_stream.sv
// Directed bench for aes_shift_rows_stream at NB = 4, 6 and 8.
// All three instances share handshake and mode; each has its own data.
module tb_aes_shift_rows_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid;
    logic         out_ready;
    logic [1:0]   in_mode;

    logic [127:0] d4, o4;
    logic [191:0] d6, o6;
    logic [255:0] d8, o8;
    logic         ir4, ir6, ir8;
    logic         ov4, ov6, ov8;
    logic         oe4, oe6, oe8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    aes_shift_rows_stream #(.NB(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir4),
        .in_data(d4), .in_mode(in_mode),
        .out_valid(ov4), .out_ready(out_ready),
        .out_data(o4), .out_err(oe4)
    );

    aes_shift_rows_stream #(.NB(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir6),
        .in_data(d6), .in_mode(in_mode),
        .out_valid(ov6), .out_ready(out_ready),
        .out_data(o6), .out_err(oe6)
    );

    aes_shift_rows_stream #(.NB(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir8),
        .in_data(d8), .in_mode(in_mode),
        .out_valid(ov8), .out_ready(out_ready),
        .out_data(o8), .out_err(oe8)
    );

    task automatic check(input string tag,
                         input logic [255:0] obs,
                         input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: state held in the low nb*32 bits of a 256-bit word.
    function automatic logic [255:0] model(input int nb,
                                           input logic [1:0] mode,
                                           input logic [255:0] d);
        logic [255:0] o;
        int w, s, sc;
        o = '0;
        w = nb * 32;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (nb == 8) s = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 3 : 4;
                else         s = r;
                if (mode == 2'b00)      sc = (c + s) % nb;
                else if (mode == 2'b01) sc = (c - s + nb) % nb;
                else                    sc = c;
                o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*sc+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [255:0] ramp(input int nb);
        logic [255:0] o;
        int w;
        o = '0;
        w = nb * 32;
        for (int k = 0; k < 4 * nb; k++)
            o[w-1-8*k -: 8] = 8'(k);
        return o;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all(input string tag, input logic [1:0] mode,
                             input logic [255:0] s4,
                             input logic [255:0] s6,
                             input logic [255:0] s8);
        check({tag, "_v4"}, 256'(ov4), 256'(1));
        check({tag, "_v8"}, 256'(ov8), 256'(1));
        check({tag, "_d4"}, 256'(o4), model(4, mode, s4));
        check({tag, "_d6"}, 256'(o6), model(6, mode, s6));
        check({tag, "_d8"}, 256'(o8), model(8, mode, s8));
    endtask

    logic [255:0] r0, s4, s6, s8;
    logic [127:0] beats [4];

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_mode   = 2'b00;
        d4 = '0;
        d6 = '0;
        d8 = '0;

        // Reset state
        #12;
        check("rst_ov", 256'(ov4), 256'(0));
        check("rst_oe", 256'(oe4), 256'(0));
        check("rst_od", 256'(o4), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ir", 256'(ir4), 256'(1));
        check("rst_ov_rel", 256'(ov8), 256'(0));

        // Forward NB=4 known vector, NB=8 ramp
        d4 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        d6 = ramp(6);
        d8 = ramp(8);
        in_mode  = 2'b00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("fwd4_vec", 256'(o4),
              256'(128'h00050a0f_04090e03_080d0207_0c01060b));
        check("fwd4_err", 256'(oe4), 256'(0));
        check("fwd8_col0", 256'(o8[255 -: 32]), 256'(32'h00050e13));
        check_all("fwd_ramp", 2'b00, 256'(d4), 256'(d6), d8);

        // Inverse NB=4 vector; NB=8 inverse of forward ramp returns ramp
        d8 = o8;
        in_mode = 2'b01;
        @(posedge clk); #1;
        check("inv4_vec", 256'(o4),
              256'(128'h000d0a07_04010e0b_0805020f_0c090603));
        check("inv8_rt", 256'(o8), ramp(8));

        // Bypass mode
        d4 = 128'h0123456789abcdeffedcba9876543210;
        in_mode = 2'b10;
        @(posedge clk); #1;
        check("byp4", 256'(o4), 256'(d4));
        check("byp4_err", 256'(oe4), 256'(0));

        // Random round trips, back-to-back on every instance
        for (int i = 0; i < 1000; i++) begin
            r0 = rnd256();
            d4 = r0[127:0];
            d6 = r0[191:0];
            d8 = r0;
            in_mode = 2'b00;
            @(posedge clk); #1;
            check_all("rt_fwd", 2'b00, 256'(d4), 256'(d6), d8);
            d4 = o4;
            d6 = o6;
            d8 = o8;
            in_mode = 2'b01;
            @(posedge clk); #1;
            check("rt4", 256'(o4), 256'(r0[127:0]));
            check("rt6", 256'(o6), 256'(r0[191:0]));
            check("rt8", 256'(o8), r0);
            check("rt_v6", 256'(ov6), 256'(1));
        end

        // Drain: output transfer with no input clears out_valid
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain_ov", 256'(ov4), 256'(0));

        // Backpressure: stall 3 cycles after first beat
        for (int i = 0; i < 4; i++)
            beats[i] = {$urandom, $urandom, $urandom, $urandom};
        in_mode  = 2'b00;
        d4 = beats[0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_b0", 256'(o4), model(4, 2'b00, 256'(beats[0])));
        out_ready = 1'b0;
        d4 = beats[1];
        #1;
        check("bp_ir0", 256'(ir4), 256'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_d", 256'(o4), model(4, 2'b00, 256'(beats[0])));
            check("bp_hold_v", 256'(ov4), 256'(1));
            check("bp_hold_ir", 256'(ir4), 256'(0));
        end
        out_ready = 1'b1;
        #1;
        check("bp_ir1", 256'(ir4), 256'(1));
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp_seq_v", 256'(ov4), 256'(1));
            check("bp_seq_d", 256'(o4), model(4, 2'b00, 256'(beats[i])));
            if (i < 3) d4 = beats[i+1];
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_end_ov", 256'(ov4), 256'(0));

        // Illegal mode: bypass data, one-beat error flag
        d4 = {4{32'hDEADBEEF}};
        in_mode  = 2'b11;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("ill_d", 256'(o4), 256'({4{32'hDEADBEEF}}));
        check("ill_err", 256'(oe4), 256'(1));
        in_mode = 2'b00;
        @(posedge clk); #1;
        check("ill_next_err", 256'(oe4), 256'(0));
        check("ill_next_d", 256'(o4),
              model(4, 2'b00, 256'({4{32'hDEADBEEF}})));

        // Async reset mid-stall
        d4 = {4{32'hCAFEF00D}};
        in_mode = 2'b11;
        @(posedge clk); #1;
        check("ar_pre_err", 256'(oe4), 256'(1));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ov", 256'(ov4), 256'(0));
        check("ar_oe", 256'(oe4), 256'(0));
        check("ar_od", 256'(o4), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        s4 = 256'(128'h00112233445566778899aabbccddeeff);
        s6 = '0;
        s8 = '0;
        d4 = s4[127:0];
        in_mode   = 2'b00;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("ar_rel_ov", 256'(ov4), 256'(0));
        check("ar_rel_ir", 256'(ir4), 256'(1));
        @(posedge clk); #1;
        check("ar_first_v", 256'(ov4), 256'(1));
        check("ar_first_d", 256'(o4), model(4, 2'b00, s4));
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
